// File: rtl/inst_hw_feeder.sv
// Thumb halfword fetch feeder: word reads into a prefetch FIFO, split into halfwords, with branch redirect.
// Optional feature: define INST_HW_FEEDER_BYPASS_EN to forward a response into an empty FIFO in the same cycle.
module inst_hw_feeder #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          QDEPTH   = 4,
  parameter int          MAX_OUT  = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        hw_ready,
  output logic [15:0] inst_hw,
  output logic        hw_valid,
  output logic [31:0] hw_pc,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);
  localparam int PW  = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int CW  = $clog2(QDEPTH + 1);
  localparam int CW1 = CW + 1;
  localparam logic [CW:0]   DEPTH_LIM = CW1'(QDEPTH);
  localparam logic [CW-1:0] OUT_LIM   = CW'(MAX_OUT);

  typedef enum logic [0:0] {FETCH = 1'b0, FLUSH = 1'b1} state_t;

  state_t        state_r;
  logic [31:0]   fifo_r [QDEPTH];
  logic [PW-1:0] head_r;
  logic [PW-1:0] tail_r;
  logic [CW-1:0] cnt_r;
  logic [CW-1:0] outstanding_r;
  logic [CW-1:0] discard_r;
  logic          sel_r;
  logic [31:0]   pc_r;
  logic [31:0]   fetch_addr_r;

  logic [CW:0]   credit_s;
  logic [CW-1:0] out_next_s;
  logic [31:0]   head_word_s;
  logic          gnt_s;
  logic          rv_s;
  logic          bypass_s;
  logic          pop_s;
  logic          push_s;
  logic          deq_s;

  assign mem_addr = fetch_addr_r;
  assign hw_pc    = pc_r;

  // Issue decision, halfword presentation and FIFO push/pop qualification.
  always_comb begin
    credit_s    = {1'b0, cnt_r} + {1'b0, outstanding_r};
    mem_req     = 1'b0;
    hw_valid    = 1'b0;
    inst_hw     = 16'h0000;
    head_word_s = fifo_r[head_r];
    if (!rst && (state_r == FETCH) && !redirect && (credit_s < DEPTH_LIM) && (outstanding_r < OUT_LIM)) begin
      mem_req = 1'b1;
    end else begin
      mem_req = 1'b0;
    end
    gnt_s = mem_req && mem_gnt;
    // A response with nothing outstanding is a memory protocol error and is ignored.
    rv_s  = mem_rvalid && (outstanding_r != '0);
`ifdef INST_HW_FEEDER_BYPASS_EN
    bypass_s = (cnt_r == '0) && (state_r == FETCH) && rv_s && !redirect;
`else
    bypass_s = 1'b0;
`endif
    if (bypass_s) begin
      hw_valid = 1'b1;
      inst_hw  = sel_r ? mem_rdata[31:16] : mem_rdata[15:0];
    end else if (cnt_r != '0) begin
      hw_valid = 1'b1;
      inst_hw  = sel_r ? head_word_s[31:16] : head_word_s[15:0];
    end else begin
      hw_valid = 1'b0;
      inst_hw  = 16'h0000;
    end
    pop_s      = hw_valid && hw_ready && !redirect;
    // A bypassed upper half that is consumed immediately never enters the FIFO.
    push_s     = (state_r == FETCH) && rv_s && !redirect && !(bypass_s && hw_ready && sel_r);
    deq_s      = pop_s && sel_r && !bypass_s;
    out_next_s = outstanding_r + CW'(gnt_s) - CW'(rv_s);
  end

  // Control state: FSM, credit counters, halfword PC/select and FIFO pointers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r       <= FETCH;
      head_r        <= '0;
      tail_r        <= '0;
      cnt_r         <= '0;
      outstanding_r <= '0;
      discard_r     <= '0;
      sel_r         <= RESET_PC[1];
      pc_r          <= {RESET_PC[31:1], 1'b0};
      fetch_addr_r  <= {RESET_PC[31:2], 2'b00};
    end else if (redirect) begin
      state_r       <= (out_next_s != '0) ? FLUSH : FETCH;
      head_r        <= '0;
      tail_r        <= '0;
      cnt_r         <= '0;
      outstanding_r <= out_next_s;
      discard_r     <= out_next_s;
      sel_r         <= redirect_pc[1];
      pc_r          <= {redirect_pc[31:1], 1'b0};
      fetch_addr_r  <= {redirect_pc[31:2], 2'b00};
    end else begin
      outstanding_r <= out_next_s;
      cnt_r         <= cnt_r + CW'(push_s) - CW'(deq_s);
      if (gnt_s) fetch_addr_r <= fetch_addr_r + 32'd4;
      if (push_s) tail_r <= tail_r + PW'(1);
      if (deq_s) head_r <= head_r + PW'(1);
      if (pop_s) begin
        pc_r  <= pc_r + 32'd2;
        sel_r <= ~sel_r;
      end
      if ((state_r == FLUSH) && rv_s) begin
        discard_r <= discard_r - CW'(1);
        if (discard_r == CW'(1)) state_r <= FETCH;
      end
    end
  end

  // Prefetch word storage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < QDEPTH; i++) fifo_r[i] <= 32'h0000_0000;
    end else if (push_s) begin
      fifo_r[tail_r] <= mem_rdata;
    end
  end
endmodule
